// File: rtl/tr_scan_pkg.sv
// tr_scan_pkg: scanner state encoding and the header nibble that tags each selector's byte group
package tr_scan_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_CAPTURE, S_HDR, S_DATA, S_FIN} state_t;
  localparam logic [3:0] HDR_NIBBLE = 4'hA;
endpackage

// File: rtl/tr_scanner.sv
// tr_scanner: on START, steps TRS through 0..NSEL-1, waits SETTLE cycles, captures TR and streams {A,sel} then TR bytes MSB-first on TX_DATA/TX_VALID/TX_READY; BUSY spans the scan, DONE pulses at the end
module tr_scanner import tr_scan_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NSEL = 16,
  parameter int SETTLE = 2
)(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic [3:0]       TRS,
  input  logic [WIDTH-1:0] TR,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic             BUSY,
  output logic             DONE
);
  localparam int NB = WIDTH / 8;
  state_t state_q, state_d;
  logic [3:0] sel_q, sel_d, trs_q, trs_d, set_q, set_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      trs_q   <= '0;
      set_q   <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      trs_q   <= trs_d;
      set_q   <= set_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    trs_d   = trs_q;
    set_d   = set_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: if (START) begin
        sel_d   = '0;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        trs_d   = sel_q;
        set_d   = 4'(SETTLE);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        set_d   = set_q - 4'd1;
        state_d = (set_q == 4'd1) ? S_CAPTURE : S_WAIT;
      end
      S_CAPTURE: begin
        sh_d    = TR;
        bcnt_d  = 2'(NB - 1);
        state_d = S_HDR;
      end
      S_HDR: state_d = TX_READY ? S_DATA : S_HDR;
      S_DATA: if (TX_READY) begin
        sh_d   = sh_q << 8;
        bcnt_d = bcnt_q - 2'd1;
        if (bcnt_q == 2'd0) begin
          state_d = (sel_q == 4'(NSEL - 1)) ? S_FIN : S_SETUP;
          sel_d   = (sel_q == 4'(NSEL - 1)) ? sel_q : sel_q + 4'd1;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign TRS      = trs_q;
  assign TX_VALID = (state_q == S_HDR) || (state_q == S_DATA);
  assign TX_DATA  = (state_q == S_HDR) ? {HDR_NIBBLE, sel_q} : (state_q == S_DATA) ? sh_q[WIDTH-1 -: 8] : 8'h00;
  assign BUSY     = (state_q != S_IDLE) && (state_q != S_FIN);
  assign DONE     = (state_q == S_FIN);
endmodule

// File: tb/tb_tr_scanner.sv
// tb_tr_scanner: directed vector bench for tr_scanner with a 2-selector and a 16-selector instance
module tb_tr_scanner;
  typedef struct {
    logic [31:0] t0;
    logic [31:0] t1;
    logic [79:0] exp;
  } vec_t;
  logic CLK = 1'b0;
  logic RESET;
  logic START2, START16, TX_READY2, TX_READY16, tog;
  logic [3:0] TRS2, TRS16;
  logic [31:0] TR2, TR16, tr0, tr1, tr_tog;
  logic [7:0] TX_DATA2, TX_DATA16;
  logic TX_VALID2, TX_VALID16, BUSY2, BUSY16, DONE2, DONE16;
  logic busy16_prev = 1'b0;
  logic [7:0] q2[$];
  logic [7:0] q16[$];
  int done2 = 0, done16 = 0, cyc = 0, busy_rise = 0, fin_cyc = 0;
  int n_tests = 0, n_fail = 0;
  int base, d0, k;
  vec_t vt[4];
  always #5 CLK = ~CLK;
  assign TR2  = tog ? tr_tog : (TRS2 == 4'd0 ? tr0 : tr1);
  assign TR16 = {4{4'h0, TRS16}};
  tr_scanner #(.WIDTH(32), .NSEL(2), .SETTLE(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .START(START2), .TRS(TRS2), .TR(TR2),
    .TX_DATA(TX_DATA2), .TX_VALID(TX_VALID2), .TX_READY(TX_READY2),
    .BUSY(BUSY2), .DONE(DONE2)
  );
  tr_scanner #(.WIDTH(32), .NSEL(16), .SETTLE(2)) dut16 (
    .CLK(CLK), .RESET(RESET), .START(START16), .TRS(TRS16), .TR(TR16),
    .TX_DATA(TX_DATA16), .TX_VALID(TX_VALID16), .TX_READY(TX_READY16),
    .BUSY(BUSY16), .DONE(DONE16)
  );
  always @(negedge CLK) begin
    cyc++;
    if (TX_VALID2 && TX_READY2) q2.push_back(TX_DATA2);
    if (DONE2) done2++;
    if (TX_VALID16 && TX_READY16) q16.push_back(TX_DATA16);
    if (DONE16) begin
      done16++;
      fin_cyc = cyc;
    end
    if (BUSY16 && !busy16_prev) busy_rise = cyc;
    busy16_prev = BUSY16;
  end
  function automatic logic [31:0] at2(input int i);
    return (i < q2.size()) ? 32'(q2[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] at16(input int i);
    return (i < q16.size()) ? 32'(q16[i]) : 32'hFFFF_FFFF;
  endfunction
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic start2;
    START2 = 1'b1;
    tick();
    START2 = 1'b0;
  endtask
  task automatic wait_done2(input string nm, input int d);
    int n = 0;
    while (done2 == d && n < 300) begin
      tick();
      n++;
    end
    chk({nm, " done"}, 32'(done2 - d), 32'd1);
  endtask
  task automatic check_stream(input string nm, input int b, input logic [79:0] exp);
    chk({nm, " count"}, 32'(q2.size() - b), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s byte%0d", nm, i), at2(b + i), 32'(exp[79 - 8*i -: 8]));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    RESET = 1'b0; START2 = 1'b0; START16 = 1'b0; TX_READY2 = 1'b1; TX_READY16 = 1'b1;
    tog = 1'b0; tr0 = '0; tr1 = '0; tr_tog = '0;
    vt[0] = '{32'h11223344, 32'hAABBCCDD, 80'hA0_11223344_A1_AABBCCDD};
    vt[1] = '{32'h00000000, 32'hFFFFFFFF, 80'hA0_00000000_A1_FFFFFFFF};
    vt[2] = '{32'h80000001, 32'h01020304, 80'hA0_80000001_A1_01020304};
    vt[3] = '{32'h5A5AA5A5, 32'hC3000000, 80'hA0_5A5AA5A5_A1_C3000000};
    repeat (3) tick();
    chk("reset trs", 32'(TRS2), 32'd0);
    chk("reset data", 32'(TX_DATA2), 32'd0);
    chk("reset valid", 32'(TX_VALID2), 32'd0);
    chk("reset busy", 32'(BUSY2), 32'd0);
    chk("reset done", 32'(DONE2), 32'd0);
    RESET = 1'b1;
    tick();
    for (int v = 0; v < 4; v++) begin
      tr0 = vt[v].t0;
      tr1 = vt[v].t1;
      base = q2.size();
      d0 = done2;
      start2();
      chk($sformatf("vec%0d busy", v), 32'(BUSY2), 32'd1);
      wait_done2($sformatf("vec%0d", v), d0);
      check_stream($sformatf("vec%0d", v), base, vt[v].exp);
      chk($sformatf("vec%0d trs hold", v), 32'(TRS2), 32'd1);
      chk($sformatf("vec%0d busy low", v), 32'(BUSY2), 32'd0);
      tick();
    end
    tr0 = vt[0].t0;
    tr1 = vt[0].t1;
    base = q2.size();
    d0 = done2;
    start2();
    for (int i = 0; i < 12; i++) begin
      TX_READY2 = !(i >= 6 && i <= 8);
      if (i >= 6 && i <= 8) begin
        chk("stall data", 32'(TX_DATA2), 32'h22);
        chk("stall valid", 32'(TX_VALID2), 32'd1);
      end
      tick();
    end
    TX_READY2 = 1'b1;
    wait_done2("stall", d0);
    check_stream("stall", base, vt[0].exp);
    tick();
    tog = 1'b1;
    tr_tog = 32'hFFFF_FFFF;
    base = q2.size();
    d0 = done2;
    start2();
    for (int i = 0; i < 18; i++) begin
      tr_tog = (i == 3) ? 32'h11223344 : (i == 12) ? 32'hAABBCCDD : (i[0] ? 32'h5555AAAA : 32'hAAAA5555);
      tick();
    end
    wait_done2("toggle", d0);
    tog = 1'b0;
    check_stream("toggle", base, vt[0].exp);
    tick();
    base = q2.size();
    d0 = done2;
    start2();
    for (int i = 0; i < 10; i++) begin
      START2 = (i == 5 || i == 8);
      tick();
    end
    START2 = 1'b0;
    wait_done2("restart", d0);
    repeat (20) tick();
    chk("restart done count", 32'(done2 - d0), 32'd1);
    check_stream("restart", base, vt[0].exp);
    base = q2.size();
    d0 = done2;
    start2();
    k = 0;
    while (q2.size() - base < 4 && k < 50) begin
      tick();
      k++;
    end
    chk("rst pre bytes", 32'(q2.size() - base), 32'd4);
    RESET = 1'b0;
    #1;
    chk("rst data", 32'(TX_DATA2), 32'd0);
    chk("rst valid", 32'(TX_VALID2), 32'd0);
    chk("rst busy", 32'(BUSY2), 32'd0);
    chk("rst done", 32'(DONE2), 32'd0);
    chk("rst trs", 32'(TRS2), 32'd0);
    repeat (3) tick();
    RESET = 1'b1;
    repeat (10) tick();
    chk("rst no done", 32'(done2 - d0), 32'd0);
    chk("rst idle bytes", 32'(q2.size() - base), 32'd4);
    chk("rst idle busy", 32'(BUSY2), 32'd0);
    base = q2.size();
    d0 = done2;
    start2();
    wait_done2("post rst", d0);
    check_stream("post rst", base, vt[0].exp);
    base = q16.size();
    d0 = done16;
    START16 = 1'b1;
    tick();
    START16 = 1'b0;
    k = 0;
    while (done16 == d0 && k < 400) begin
      tick();
      k++;
    end
    repeat (5) tick();
    chk("n16 done", 32'(done16 - d0), 32'd1);
    chk("n16 count", 32'(q16.size() - base), 32'd80);
    chk("n16 first hdr", at16(base), 32'hA0);
    chk("n16 last hdr", at16(base + 75), 32'hAF);
    chk("n16 last byte", at16(base + 79), 32'h0F);
    chk("n16 cycles", 32'(fin_cyc - busy_rise), 32'd144);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
